// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button inputs and conditioned outputs.
//   btn_raw    : asynchronous raw buttons ([0] start_stop, [1] lap_time, [2] clear)
//   level      : debounced button levels
//   press      : one-cycle pulse per accepted rising edge of level
//   long_press : one-cycle pulse once channel 2 has been held long enough
// master drives btn_raw (button side); slave is the conditioner.
interface button_conditioner_if;
  logic [2:0] btn_raw;
  logic [2:0] level;
  logic [2:0] press;
  logic       long_press;

  modport master (output btn_raw, input level, press, long_press);
  modport slave  (input btn_raw, output level, press, long_press);
endinterface

// File: rtl/button_conditioner.sv
// Three-channel button conditioner: synchronize, debounce, rising-edge press
// pulse, and optional long-press detection on channel 2.
//   clk : system clock
//   res : asynchronous active-high reset
//   bus : button_conditioner_if.slave (btn_raw in; level, press, long_press out)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a level change (>= 2)
//   LONG_CYCLES     : held cycles on channel 2 before long_press (>= 2)
// Macro BUTTON_CONDITIONER_LONG_PRESS_EN enables the long-press hold counter;
// without it long_press is tied low.

// One debounce lane: 2-flop synchronizer followed by a qualification counter.
module button_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic res,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
          // Pulse only when the accepted level is high (rising edge).
          press <= s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Any sample matching the current level restarts qualification.
        cnt <= '0;
      end
    end
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 200000000
) (
  input  logic                 clk,
  input  logic                 res,
  button_conditioner_if.slave  bus
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0] lvl;
  logic [NUM_LANES-1:0] prs;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      button_conditioner_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_lane (
        .clk   (clk),
        .res   (res),
        .raw   (bus.btn_raw[i]),
        .level (lvl[i]),
        .press (prs[i])
      );
    end
  endgenerate

  assign bus.level = lvl;
  assign bus.press = prs;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          long_q;

  // Counts cycles with level[2] high; pulses on reaching HOLD_MAX, then
  // saturates so a continued hold never repeats the pulse.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!lvl[2]) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
        long_q   <= (hold_cnt == HOLD_LAST);
      end
    end
  end

  assign bus.long_press = long_q;
`else
  localparam int UNUSED_LONG_CYCLES = LONG_CYCLES;
  assign bus.long_press = 1'b0;
`endif
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal values are 2 and above.
REQ-002 The block SHALL expose parameter LONG_CYCLES, default 200000000, meaning held cycles on channel 2 before a long-press pulse (2 s at 100 MHz); legal values are 2 and above.
REQ-003 The clock port SHALL be: clk, input, 1 bit, system clock (100 MHz).
REQ-004 The reset port SHALL be: res, input, 1 bit, asynchronous, active-high reset.
REQ-005 Port btn_raw SHALL be: input, 3 bits, asynchronous raw buttons; [0] start_stop, [1] lap_time, [2] clear.
REQ-006 Port level SHALL be: output, 3 bits, debounced button levels.
REQ-007 Port press SHALL be: output, 3 bits, one-cycle pulse on each accepted rising edge of level.
REQ-008 Port long_press SHALL be: output, 1 bit, one-cycle pulse when channel 2 has been held LONG_CYCLES.

Function
REQ-009 Each channel SHALL pass btn_raw through a two-flop synchronizer (s1, s2) before any other logic.
REQ-010 Each channel SHALL hold an independent counter of width clog2(DEBOUNCE_CYCLES+1) bits.
REQ-011 On an edge where s2 != level: the counter SHALL increment; if it already equals DEBOUNCE_CYCLES-1, level SHALL take s2 and the counter SHALL clear.
REQ-012 On an edge where s2 == level, the counter SHALL clear, so a bounce restarts qualification from zero.
REQ-013 Latency: with raw held high from clock edge 1, level and press[i] SHALL rise together after edge 2+DEBOUNCE_CYCLES.
REQ-014 press[i] SHALL be registered, high for exactly one cycle per 0->1 level transition, and low on 1->0 transitions.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL change neither level nor press.
REQ-016 Channels SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses.

Reset
REQ-017 While res is high, all of the following SHALL be 0 immediately, with no clock required: s1, s2, counters, level, press, long_press, and the hold counter.
REQ-018 A button held through reset deassertion SHALL be treated as a new press after the full REQ-013 latency.
REQ-019 Asserting res mid-qualification or mid-hold SHALL discard all progress, with no pulse emitted.

Configuration
REQ-020 With macro BUTTON_CONDITIONER_LONG_PRESS_EN defined, a hold counter of width clog2(LONG_CYCLES+1) bits SHALL implement long-press detection as follows.
- The counter increments each cycle while level[2] is 1.
- On the cycle the counter reaches LONG_CYCLES, long_press pulses once.
- The counter then saturates with no repeat pulse.
- The counter clears when level[2] is 0.
REQ-021 Without BUTTON_CONDITIONER_LONG_PRESS_EN defined, long_press SHALL be tied to 0 and no hold counter SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-022 Clean press: btn_raw[0] 0->1 and held -> level[0] and press[0] rise after edge 6; press[0] is high for 1 cycle.
REQ-023 Bounce rejection: btn_raw[1] high for 3 cycles, low for 1, then held high -> exactly one press[1], arriving 6 edges after the final rise.
REQ-024 Release: held btn_raw[0] goes low -> level[0] falls 6 edges later and press[0] stays 0.
REQ-025 Simultaneous press: btn_raw=3'b111 at once -> press=3'b111 in the same cycle.
REQ-026 Reset mid-operation: res pulsed 2 cycles into qualification -> outputs immediately 0; a button held afterwards presses 6 edges after res falls.
REQ-027 Long press (macro defined): btn_raw[2] held 40 cycles -> exactly one long_press, 20 cycles after level[2] rose; without the macro, long_press stays 0.
